// File: rtl/ysyx_25030085_lsu.sv
// ysyx_25030085_lsu: multi-cycle load/store unit between the execute stage
// and a valid/ready data-memory bus. It places store bytes on their lanes,
// builds the write strobes, extracts and extends load data, and reports
// misaligned, illegal and timed-out accesses back to the core.
module ysyx_25030085_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic [1:0]  err_cause,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_we,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wstrb,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_rdata,
  output logic        bus_resp_ready
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrMisalign = 2'b01;
  localparam logic [1:0] ErrTimeout  = 2'b10;
  localparam logic [1:0] ErrIllegal  = 2'b11;

  // Last counter value that may still see a handshake; anything at or past
  // it without a handshake aborts the access.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  offs_q, offs_d;
  logic        we_q, we_d;
  logic [31:0] reqAddr_q, reqAddr_d;
  logic [31:0] reqWdata_q, reqWdata_d;
  logic [3:0]  reqWstrb_q, reqWstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  errCause_q, errCause_d;

  logic        startAccess;
  logic        illegalAccess;
  logic        misalignedAccess;
  logic [31:0] storeData;
  logic [3:0]  storeStrb;
  logic [31:0] loadData;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic        timeoutHit;

  assign startAccess = lsu_valid & (mem_read | mem_write);
  assign timeoutHit  = (cnt_q >= TimeoutLast);

  // Classify the incoming access; illegal encodings take priority over alignment.
  always_comb begin
    illegalAccess    = 1'b0;
    misalignedAccess = 1'b0;
    if (mem_read && mem_write) begin
      illegalAccess = 1'b1;
    end else if (mem_read) begin
      illegalAccess = (mem_op == 3'b011) || (mem_op == 3'b110) || (mem_op == 3'b111);
    end else if (mem_write) begin
      illegalAccess = (mem_op != 3'b000) && (mem_op != 3'b001) && (mem_op != 3'b010);
    end
    if (mem_op[1:0] == 2'b01) begin
      misalignedAccess = addr[0];
    end else if (mem_op == 3'b010) begin
      misalignedAccess = (addr[1:0] != 2'b00);
    end
  end

  // Shift store data onto its byte lanes and build the matching strobes.
  always_comb begin
    storeData = 32'h0;
    storeStrb = 4'b0000;
    if (mem_write) begin
      case (mem_op[1:0])
        2'b00: begin
          storeData = {24'h0, wdata[7:0]} << {addr[1:0], 3'b000};
          storeStrb = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          storeData = {16'h0, wdata[15:0]} << {addr[1], 4'b0000};
          storeStrb = 4'b0011 << {addr[1], 1'b0};
        end
        default: begin
          storeData = wdata;
          storeStrb = 4'b1111;
        end
      endcase
    end
  end

  // Pull the addressed lane out of the returned word and extend it.
  always_comb begin
    loadByte = 8'(bus_resp_rdata >> {offs_q, 3'b000});
    loadHalf = 16'(bus_resp_rdata >> {offs_q[1], 4'b0000});
    case (op_q)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b100:  loadData = {24'h0, loadByte};
      3'b101:  loadData = {16'h0, loadHalf};
      default: loadData = bus_resp_rdata;
    endcase
  end

  // Sequence an access through capture, request, response and completion.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    offs_d     = offs_q;
    we_d       = we_q;
    reqAddr_d  = reqAddr_q;
    reqWdata_d = reqWdata_q;
    reqWstrb_d = reqWstrb_q;
    rdata_d    = rdata_q;
    errCause_d = errCause_q;
    case (state_q)
      StIdle: begin
        if (startAccess) begin
          op_d       = mem_op;
          offs_d     = addr[1:0];
          we_d       = mem_write;
          reqAddr_d  = {addr[31:2], 2'b00};
          reqWdata_d = storeData;
          reqWstrb_d = storeStrb;
          if (illegalAccess) begin
            errCause_d = ErrIllegal;
            state_d    = StDone;
          end else if (misalignedAccess) begin
            errCause_d = ErrMisalign;
            state_d    = StDone;
          end else begin
            errCause_d = ErrNone;
            cnt_d      = 8'd0;
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_req_ready) begin
          state_d = StResp;
        end else if (timeoutHit) begin
          errCause_d = ErrTimeout;
          state_d    = StDone;
        end
      end
      StResp: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_resp_valid) begin
          if (!we_q) begin
            rdata_d = loadData;
          end
          state_d = StDone;
        end else if (timeoutHit) begin
          errCause_d = ErrTimeout;
          state_d    = StDone;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Register the FSM, the captured request and the completion results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      op_q       <= 3'b000;
      offs_q     <= 2'b00;
      we_q       <= 1'b0;
      reqAddr_q  <= 32'h0;
      reqWdata_q <= 32'h0;
      reqWstrb_q <= 4'b0000;
      rdata_q    <= 32'h0;
      errCause_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      offs_q     <= offs_d;
      we_q       <= we_d;
      reqAddr_q  <= reqAddr_d;
      reqWdata_q <= reqWdata_d;
      reqWstrb_q <= reqWstrb_d;
      rdata_q    <= rdata_d;
      errCause_q <= errCause_d;
    end
  end

  assign lsu_busy       = (state_q != StIdle);
  assign lsu_done       = (state_q == StDone);
  assign lsu_rdata      = rdata_q;
  assign err_cause      = errCause_q;
  assign lsu_err        = (errCause_q != ErrNone);
  assign bus_req_valid  = (state_q == StReq);
  assign bus_resp_ready = (state_q == StResp);
  assign bus_req_we     = we_q;
  assign bus_req_addr   = reqAddr_q;
  assign bus_req_wdata  = reqWdata_q;
  assign bus_req_wstrb  = reqWstrb_q;

endmodule

// File: doc/ysyx_25030085_lsu.md
# ysyx_25030085_lsu

Multi-cycle load/store unit that executes the memory accesses requested by the control unit's MemRead/MemWrite/MemOp signals. It sits between the core's execute stage and a valid/ready data-memory bus. It handles byte-lane placement and write strobes for stores, and lane extraction plus sign/zero extension for loads. It reports completion, misaligned or illegal accesses, and bus timeouts back to the core.

## Interface
Parameters:
- TIMEOUT, 255, maximum number of cycles spent in REQ+RESP before aborting (1..255; counter is 8 bits)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- lsu_valid  in  1  core presents an access; held until lsu_done
- mem_read  in  1  load request (MemRead)
- mem_write  in  1  store request (MemWrite)
- mem_op  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu (MemOp)
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (rs2)
- lsu_busy  out  1  high in any state except IDLE
- lsu_done  out  1  one-cycle completion pulse
- lsu_rdata  out  32  extended load result, valid when lsu_done
- lsu_err  out  1  error flag, valid when lsu_done
- err_cause  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal op
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  memory accepts request
- bus_req_we  out  1  1 store, 0 load
- bus_req_addr  out  32  word address {addr[31:2],2'b00}
- bus_req_wdata  out  32  lane-shifted store data
- bus_req_wstrb  out  4  byte strobes (0000 for loads)
- bus_resp_valid  in  1  response/ack valid
- bus_resp_rdata  in  32  raw read word
- bus_resp_ready  out  1  LSU accepts response

## Operation
- FSM: IDLE, REQ, RESP, DONE.
- IDLE: on lsu_valid and (mem_read or mem_write), capture mem_op, addr, wdata and direction, then check the access:
  - illegal if both read and write are set, if a load uses op 011/110/111, or if a store uses any op other than 000/001/010 -> DONE, err 11;
  - otherwise misaligned if (h/hu and addr[0]) or (w and addr[1:0]!=0) -> DONE, err 01;
  - otherwise -> REQ.
- Check priority: illegal over misaligned.
- lsu_valid with neither read nor write is ignored.
- REQ: bus_req_valid=1, with all req fields driven from captured values and held stable. If bus_req_ready -> RESP.
- RESP: bus_resp_ready=1. If bus_resp_valid -> DONE.
  - Loads latch the extended data.
  - Stores also wait for the response as a write ack; rdata is ignored.
- DONE: lsu_done=1 for exactly one cycle, then -> IDLE. No capture occurs in DONE.
- Stores:
  - sb: wdata = wdata[7:0] << 8*addr[1:0], wstrb = 0001 << addr[1:0].
  - sh: wdata = wdata[15:0] << 16*addr[1], wstrb = 0011 << 2*addr[1].
  - sw: wdata unchanged, wstrb = 1111.
- Loads:
  - byte = rdata >> 8*addr[1:0]; half = rdata >> 16*addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- lsu_rdata is held from DONE until the next completed load; errors and stores do not change it.
- Timeout: the counter clears on entry to REQ and increments every cycle in REQ or RESP. When the counter reaches TIMEOUT-1 without a handshake -> DONE, err 10, with bus_req_valid/bus_resp_ready deasserted. A handshake in that same cycle wins over the timeout.

## Timing
- Reset (sync): state IDLE; counter 0; lsu_busy, lsu_done, lsu_err, bus_req_valid, bus_req_we, bus_resp_ready = 0; err_cause, wstrb = 0; lsu_rdata, bus_req_addr, bus_req_wdata = 0.
- Reset mid-operation aborts with no done pulse. bus_req_valid and bus_resp_ready are 0 from the cycle after the reset edge.
- Capture at cycle N. With ready and resp_valid both immediately high: REQ N+1, RESP N+2, lsu_done N+3.
- Error accesses: lsu_done at N+1; the bus is never touched.
- lsu_done always follows the response handshake cycle by exactly one cycle.
- The core must deassert lsu_valid in the lsu_done cycle. lsu_valid still high in the following IDLE cycle starts a new access.
- lsu_busy is registered: high from N+1 through the DONE cycle.

## Test plan
- lw 0x8000_0004, ready/resp immediate, rdata 0xDEADBEEF -> bus_req_addr 0x8000_0004, wstrb 0000, we 0; lsu_done at N+3, lsu_rdata 0xDEADBEEF, err 0.
- lb then lbu at 0x8000_0003, resp 0x80FF_FFFF -> lsu_rdata 0xFFFF_FF80, then 0x0000_0080. lh at 0x8000_0002, resp 0x8001_0000 -> 0xFFFF_8001.
- sh 0x8000_0002, wdata 0x1234_ABCD -> addr 0x8000_0000, wdata 0xABCD_0000, wstrb 1100, we 1. sb 0x8000_0001, wdata 0xFF -> wdata 0x0000_FF00, wstrb 0010.
- lw 0x8000_0002 -> done at N+1, err_cause 01, bus_req_valid never high. mem_read and mem_write both set -> err_cause 11.
- ready low for 3 cycles, then resp_valid after 2 more cycles -> request fields stable while waiting; done one cycle after the resp handshake (N+8); no early done.
- TIMEOUT=8 with ready never asserted -> err_cause 10, done at N+9. Separately, assert rst while in RESP -> IDLE, no done pulse, bus_resp_ready 0 on the next cycle.
